eeprom_req_arbiter: RTL and testbench

Arbiter and sequencer that shares one byte-level I2C EEPROM engine between two requesters. Example requesters are a key-driven writer and a periodic readback/display reader. It grants requests round-robin and passes each as a single-cycle start command to the engine. It retries NACKed transfers, which also covers ACK-polling after a write. After every successful write it enforces the 24C02 internal write-cycle time before issuing anything else. It sits between the user logic and the I2C bit-level engine on the 50 MHz board clock.

---
 rtl/eeprom_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_eeprom_req_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one byte-level I2C EEPROM engine between two requesters,
// with NACK retry (ACK polling) and a post-write hold for the EEPROM internal write cycle.
module eeprom_req_arbiter #(
   parameter int unsigned TWR_CYCLES = 250000,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rq0_req,
   input  logic       rq0_we,
   input  logic [7:0] rq0_addr,
   input  logic [7:0] rq0_wdata,
   input  logic       rq1_req,
   input  logic       rq1_we,
   input  logic [7:0] rq1_addr,
   input  logic [7:0] rq1_wdata,
   output logic       rq0_done,
   output logic       rq1_done,
   output logic [7:0] rq_rdata,
   output logic       rq_err,
   output logic       arb_busy,
   output logic       eng_start,
   output logic       eng_we,
   output logic [7:0] eng_addr,
   output logic [7:0] eng_wdata,
   input  logic       eng_busy,
   input  logic       eng_done,
   input  logic       eng_nack,
   input  logic [7:0] eng_rdata
);

   localparam int unsigned RW = (MAX_RETRY > 0)  ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned HW = (TWR_CYCLES > 1) ? $clog2(TWR_CYCLES)    : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;

   state_t          state_q, state_d;
   logic            last_q, last_d;
   logic            gnt_q, gnt_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            we_q, we_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            start_q, start_d;
   logic            done0_q, done0_d;
   logic            done1_q, done1_d;
   logic            err_q, err_d;
   logic [7:0]      rdata_q, rdata_d;
   // Engine response is registered first, giving done its one-cycle latency.
   logic            edone_q, enack_q;
   logic [7:0]      erdata_q;
   logic            pick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         gnt_q    <= 1'b0;
         retry_q  <= '0;
         hold_q   <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         start_q  <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         edone_q  <= 1'b0;
         enack_q  <= 1'b0;
         erdata_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         retry_q  <= retry_d;
         hold_q   <= hold_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         start_q  <= start_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         edone_q  <= eng_done;
         enack_q  <= eng_nack;
         erdata_q <= eng_rdata;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      retry_d = retry_q;
      hold_d  = hold_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      start_d = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;
      pick    = 1'b0;
      case (state_q)
         IDLE: begin
            if ((rq0_req || rq1_req) && !eng_busy) begin
               // On a tie the requester not served last wins.
               pick    = (rq0_req && rq1_req) ? ~last_q : rq1_req;
               gnt_d   = pick;
               we_d    = pick ? rq1_we    : rq0_we;
               addr_d  = pick ? rq1_addr  : rq0_addr;
               wdata_d = pick ? rq1_wdata : rq0_wdata;
               retry_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            start_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (edone_q) begin
               if (enack_q && (retry_q < RW'(MAX_RETRY))) begin
                  retry_d = retry_q + RW'(1);
                  state_d = ISSUE;
               end else begin
                  done0_d = ~gnt_q;
                  done1_d = gnt_q;
                  last_d  = gnt_q;
                  err_d   = enack_q;
                  if (enack_q) begin
                     state_d = IDLE;
                  end else if (we_q) begin
                     hold_d  = HW'(TWR_CYCLES - 1);
                     state_d = HOLD;
                  end else begin
                     rdata_d = erdata_q;
                     state_d = IDLE;
                  end
               end
            end
         end
         HOLD: begin
            if (hold_q == '0) state_d = IDLE;
            else              hold_d  = hold_q - HW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   assign rq0_done  = done0_q;
   assign rq1_done  = done1_q;
   assign rq_rdata  = rdata_q;
   assign rq_err    = err_q;
   assign arb_busy  = (state_q != IDLE);
   assign eng_start = start_q;
   assign eng_we    = we_q;
   assign eng_addr  = addr_q;
   assign eng_wdata = wdata_q;

endmodule

// File: tb/tb_eeprom_req_arbiter.sv
// Directed bench for eeprom_req_arbiter: scripted engine replies, hand-computed expectations.
module tb_eeprom_req_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rq0_req = 1'b0, rq0_we = 1'b0;
   logic [7:0] rq0_addr = '0, rq0_wdata = '0;
   logic       rq1_req = 1'b0, rq1_we = 1'b0;
   logic [7:0] rq1_addr = '0, rq1_wdata = '0;
   logic       rq0_done, rq1_done, rq_err, arb_busy, eng_start, eng_we;
   logic [7:0] rq_rdata, eng_addr, eng_wdata;
   logic       eng_busy = 1'b0, eng_done = 1'b0, eng_nack = 1'b0;
   logic [7:0] eng_rdata = '0;

   int ncmp = 0, nfail = 0;
   int n_start = 0, n_done0 = 0, n_done1 = 0;

   eeprom_req_arbiter #(.TWR_CYCLES(20), .MAX_RETRY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
      .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
      .rq0_done(rq0_done), .rq1_done(rq1_done), .rq_rdata(rq_rdata), .rq_err(rq_err),
      .arb_busy(arb_busy), .eng_start(eng_start), .eng_we(eng_we), .eng_addr(eng_addr),
      .eng_wdata(eng_wdata), .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack),
      .eng_rdata(eng_rdata)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (eng_start === 1'b1) n_start++;
      if (rq0_done === 1'b1)  n_done0++;
      if (rq1_done === 1'b1)  n_done1++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_start(input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (eng_start !== 1'b1 && n < 80);
      chk({tag, "_start_seen"}, 32'(eng_start), 32'd1);
   endtask

   task automatic wait_done(input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((rq0_done | rq1_done) !== 1'b1 && n < 80);
      chk({tag, "_done_seen"}, 32'(rq0_done | rq1_done), 32'd1);
   endtask

   task automatic reply(input logic nack, input logic [7:0] rd, input int lat);
      eng_busy = 1'b1;
      repeat (lat) step();
      eng_done  = 1'b1;
      eng_nack  = nack;
      eng_rdata = rd;
      step();
      eng_done  = 1'b0;
      eng_nack  = 1'b0;
      eng_busy  = 1'b0;
   endtask

   function automatic logic [31:0] outs();
      return 32'({rq0_done, rq1_done, rq_err, rq_rdata, arb_busy, eng_start, eng_we, eng_addr, eng_wdata});
   endfunction

   initial begin
      int n, gap, s0, d0, d1;
      logic busy_ok;

      // Reset state
      step(); step();
      chk("reset_outputs", outs(), 32'd0);
      rst_n = 1'b1;
      step();

      // Single read by rq0
      s0 = n_start; d0 = n_done0;
      rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 8'h03;
      wait_start("rd", n);
      chk("rd_start_latency", n, 2);
      chk("rd_eng_we", eng_we, 1'b0);
      chk("rd_eng_addr", eng_addr, 8'h03);
      reply(1'b0, 8'hF1, 3);
      wait_done("rd", n);
      chk("rd_done_latency", n, 1);
      chk("rd_done_who", {rq0_done, rq1_done}, 2'b10);
      chk("rd_rdata", rq_rdata, 8'hF1);
      chk("rd_err", rq_err, 1'b0);
      rq0_req = 1'b0;
      step();
      chk("rd_no_hold", arb_busy, 1'b0);
      chk("rd_done_one_cycle", rq0_done, 1'b0);
      chk("rd_start_count", n_start - s0, 1);
      chk("rd_done_count", n_done0 - d0, 1);

      // Write by rq1, then rq0 read blocked by the write-cycle hold
      rq1_req = 1'b1; rq1_we = 1'b1; rq1_addr = 8'h10; rq1_wdata = 8'hA5;
      wait_start("wr", n);
      chk("wr_eng_we", eng_we, 1'b1);
      chk("wr_eng_addr", eng_addr, 8'h10);
      chk("wr_eng_wdata", eng_wdata, 8'hA5);
      reply(1'b0, 8'h00, 2);
      wait_done("wr", n);
      chk("wr_done_who", {rq0_done, rq1_done}, 2'b01);
      chk("wr_err", rq_err, 1'b0);
      rq1_req = 1'b0;
      step();
      rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 8'h20;
      busy_ok = 1'b1;
      for (int i = 1; i < 19; i++) begin
         busy_ok &= arb_busy;
         step();
      end
      busy_ok &= arb_busy;
      chk("hold_busy", busy_ok, 1'b1);
      wait_start("hold", n);
      gap = 19 + n;
      chk("hold_gap_ge_22", 32'(gap >= 22), 32'd1);
      chk("hold_rd_addr", eng_addr, 8'h20);
      reply(1'b0, 8'h5A, 2);
      wait_done("hold", n);
      chk("hold_rd_who", {rq0_done, rq1_done}, 2'b10);
      chk("hold_rd_rdata", rq_rdata, 8'h5A);
      rq0_req = 1'b0;

      // Tie round-robin out of reset
      step();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 8'h01;
      rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 8'h02;
      for (int i = 0; i < 4; i++) begin
         wait_start("rr", n);
         chk("rr_addr", eng_addr, (i % 2 == 0) ? 8'h01 : 8'h02);
         reply(1'b0, 8'h40 + 8'(i), 2);
         wait_done("rr", n);
         chk("rr_done_who", {rq0_done, rq1_done}, (i % 2 == 0) ? 2'b10 : 2'b01);
         chk("rr_rdata", rq_rdata, 8'h40 + 8'(i));
      end
      rq0_req = 1'b0; rq1_req = 1'b0;
      step();

      // ACK polling: NACK, NACK, ACK on a write
      s0 = n_start; d0 = n_done0;
      rq0_req = 1'b1; rq0_we = 1'b1; rq0_addr = 8'h44; rq0_wdata = 8'h77;
      wait_start("poll0", n);
      reply(1'b1, 8'h00, 2);
      wait_start("poll1", n);
      chk("poll_retry_latency", n, 2);
      chk("poll_retry_addr", eng_addr, 8'h44);
      chk("poll_no_early_done", n_done0 - d0, 0);
      reply(1'b1, 8'h00, 2);
      wait_start("poll2", n);
      reply(1'b0, 8'h00, 2);
      wait_done("poll", n);
      chk("poll_done_who", {rq0_done, rq1_done}, 2'b10);
      chk("poll_err", rq_err, 1'b0);
      rq0_req = 1'b0;
      step();
      chk("poll_start_count", n_start - s0, 3);
      chk("poll_done_count", n_done0 - d0, 1);

      // Retry exhaustion on rq1 read (also waits out the poll's write hold)
      s0 = n_start; d1 = n_done1;
      rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 8'h55;
      for (int i = 0; i < 3; i++) begin
         wait_start("exh", n);
         reply(1'b1, 8'hEE, 2);
      end
      wait_done("exh", n);
      chk("exh_done_who", {rq0_done, rq1_done}, 2'b01);
      chk("exh_err", rq_err, 1'b1);
      rq1_req = 1'b0;
      step();
      chk("exh_no_hold", arb_busy, 1'b0);
      repeat (5) step();
      chk("exh_start_count", n_start - s0, 3);
      chk("exh_done_count", n_done1 - d1, 1);

      // Reset while waiting on the engine
      rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 8'h66;
      wait_start("rst", n);
      eng_busy = 1'b1;
      step(); step();
      d0 = n_done0; d1 = n_done1;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", outs(), 32'd0);
      eng_busy = 1'b0;
      rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 8'h77;
      repeat (3) step();
      chk("rst_no_done", (n_done0 - d0) + (n_done1 - d1), 0);
      rst_n = 1'b1;
      wait_start("rst_after", n);
      chk("rst_prio_latency", n, 2);
      chk("rst_prio_addr", eng_addr, 8'h77);
      reply(1'b0, 8'h99, 2);
      wait_done("rst_after", n);
      chk("rst_after_who", {rq0_done, rq1_done}, 2'b10);
      chk("rst_after_rdata", rq_rdata, 8'h99);
      rq0_req = 1'b0;
      wait_start("rst_pend", n);
      chk("rst_pend_addr", eng_addr, 8'h66);
      reply(1'b0, 8'h42, 2);
      wait_done("rst_pend", n);
      chk("rst_pend_who", {rq0_done, rq1_done}, 2'b01);
      chk("rst_pend_rdata", rq_rdata, 8'h42);
      rq1_req = 1'b0;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
